multi_led_counter: RTL and testbench
====================================

# multi_led_counter

Parametrised multi-channel LED counter: each channel has its own prescaler and an 8-bit (by default) display value that steps once per prescaler period. It extends the single-channel fixed-step LED counter with:
- per-channel runtime step and mode (hold / up / down / bounce),
- a configuration handshake,
- per-channel tick outputs.

It sits at top level, driving LED banks or feeding status logic.

## Interface
Parameters:
- CHANNELS, 4, number of independent channels (1..16)
- WIDTH, 8, LED value width per channel
- CNT_WIDTH, 32, prescaler counter and step width
- STEP, 10, reset value of every channel's step

Ports:
- CLK  input  1  sole clock, all logic on posedge
- RST  input  1  reset, synchronous, active-high
- cfg_valid  input  1  configuration request
- cfg_ready  output  1  block can accept configuration
- cfg_ch  input  clog2(CHANNELS) (min 1)  target channel
- cfg_step  input  CNT_WIDTH  new step (cycles per LED update)
- cfg_mode  input  2  0 hold, 1 up, 2 down, 3 bounce
- cfg_clear  input  1  also zero the channel's LED value
- LED  output  CHANNELS*WIDTH  channel n at bits [n*WIDTH +: WIDTH], registered
- tick  output  CHANNELS  one-cycle pulse when channel n's LED value updates, registered

## Operation
Per-channel state:
- count (CNT_WIDTH)
- step (CNT_WIDTH)
- mode (2)
- dir (1; 0 = up)
- LED value (WIDTH)

Reset, effective at the first posedge with RST high:
- LED = 0, tick = 0, count = 0
- step = STEP, mode = 1 (up), dir = 0
- cfg_ready = 0; it goes to 1 on the first edge with RST low.

Prescaler:
- Effective step is max(step, 1); step 0 behaves as 1.
- Each cycle in mode 0 (hold): count holds, LED holds, no tick.
- Otherwise, if count == effective step − 1:
  - count <= 0,
  - LED updates per mode,
  - tick[n] <= 1 for the next cycle.
- Else count <= count + 1.

LED update per mode:
- up: LED + 1, modulo 2^WIDTH (all-ones wraps to 0)
- down: LED − 1, modulo 2^WIDTH (0 wraps to all-ones)
- bounce:
  - dir 0 and LED == all-ones: dir <= 1, LED <= all-ones − 1.
  - dir 1 and LED == 0: dir <= 0, LED <= 1.
  - Otherwise step in direction dir.
  - Endpoints are each shown for exactly one period.

Configuration:
- Accepted on a posedge with cfg_valid && cfg_ready.
- A request with cfg_ch ≥ CHANNELS is accepted and ignored.
- A valid accept on channel cfg_ch loads step <= cfg_step and mode <= cfg_mode, and sets count <= 0 and dir <= 0.
- LED <= 0 if cfg_clear, else the LED value is unchanged.
- cfg_ready is 1 whenever not in reset; there is no backpressure after reset.

Simultaneous events:
- Config on channel n in the same cycle as n's terminal count: config wins; no LED update and no tick that cycle.
- Other channels are unaffected by any config.

## Timing
- LED and tick change only on posedge CLK; no combinational path from inputs to outputs.
- With constant step S ≥ 1 and a non-hold mode, LED changes every S cycles.
  - First update after reset: LED reads 1 after the S-th edge following RST falling.
  - tick is high in the same cycle LED shows the new value.
- New config takes effect on the accepting edge. The next LED update is exactly S' cycles later, where S' = max(cfg_step, 1).
- RST asserted mid-period: all state returns to reset values on that edge; any pending tick is dropped.
- Channels are fully independent, so several ticks may assert in the same cycle.

## Test plan
- Reset then default run (STEP=10, WIDTH=8): LED[7:0] = 0 for 10 cycles, then 1 with tick[0] one cycle; 0xFF→0x00 wrap after 2560 cycles.
- Config ch1 step=3 mode=2 clear=1: LED ch1 = 0, then 0xFF, 0xFE every 3 cycles; ch0 sequence undisturbed.
- Config ch2 step=1 mode=3 after preloading via up to 0xFE: observe 0xFF, 0xFE, …, 0x01, 0x00, 0x01; each endpoint held one cycle.
- Config ch0 in the exact cycle count == step−1: no tick, LED unchanged, next update step cycles after config; mode 0 freezes LED with no ticks; step=0 updates every cycle.
- RST pulsed mid-period with LED = 0x37: next cycle LED = 0, tick = 0, cfg_ready = 0; count restarts, first update 10 cycles after release.
- cfg_ch = CHANNELS (out of range): accepted, no channel changes.

Source files
------------

// File: rtl/multi_led_counter.sv
// rtl/multi_led_counter.sv - multi-channel LED counter with per-channel prescaler, step, mode and config handshake
module multi_led_counter #(
   parameter int CHANNELS  = 4,
   parameter int WIDTH     = 8,
   parameter int CNT_WIDTH = 32,
   parameter int STEP      = 10
) (
   input  logic                                               CLK,
   input  logic                                               RST,
   input  logic                                               cfg_valid,
   output logic                                               cfg_ready,
   input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
   input  logic [CNT_WIDTH-1:0]                               cfg_step,
   input  logic [1:0]                                         cfg_mode,
   input  logic                                               cfg_clear,
   output logic [CHANNELS*WIDTH-1:0]                          LED,
   output logic [CHANNELS-1:0]                                tick
);

   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   localparam logic [1:0] MODE_HOLD   = 2'd0;
   localparam logic [1:0] MODE_UP     = 2'd1;
   localparam logic [1:0] MODE_DOWN   = 2'd2;
   localparam logic [1:0] MODE_BOUNCE = 2'd3;

   localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

   // handshake is open whenever the block is out of reset; no backpressure
   always_ff @(posedge CLK) begin
      if (RST) begin
         cfg_ready <= 1'b0;
      end else begin
         cfg_ready <= 1'b1;
      end
   end

   for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
      logic [CNT_WIDTH-1:0] count;
      logic [CNT_WIDTH-1:0] step;
      logic [1:0]           mode;
      logic                 dir;
      logic [WIDTH-1:0]     led;
      logic                 tk;

      logic [CNT_WIDTH-1:0] last_count;
      logic                 terminal;
      logic                 hit;
      logic [WIDTH-1:0]     led_nx;
      logic                 dir_nx;

      // step 0 behaves as 1, so the terminal count is then also 0
      assign last_count = (step == '0) ? '0 : step - 1'b1;
      assign terminal   = (count == last_count);
      // out-of-range cfg_ch matches no channel and is silently dropped
      assign hit        = cfg_valid && cfg_ready && (cfg_ch == CH_W'(n));

      // next LED value and bounce direction for a terminal-count update
      always_comb begin
         led_nx = led;
         dir_nx = dir;
         case (mode)
            MODE_UP:   led_nx = led + 1'b1;
            MODE_DOWN: led_nx = led - 1'b1;
            MODE_BOUNCE: begin
               if (!dir && led == ONES) begin
                  dir_nx = 1'b1;
                  led_nx = ONES - 1'b1;
               end else if (dir && led == '0) begin
                  dir_nx = 1'b0;
                  led_nx = {{(WIDTH-1){1'b0}}, 1'b1};
               end else if (dir) begin
                  led_nx = led - 1'b1;
               end else begin
                  led_nx = led + 1'b1;
               end
            end
            default: begin
               led_nx = led;
               dir_nx = dir;
            end
         endcase
      end

      // channel state: config has priority over a coinciding terminal count
      always_ff @(posedge CLK) begin
         if (RST) begin
            count <= '0;
            step  <= CNT_WIDTH'(STEP);
            mode  <= MODE_UP;
            dir   <= 1'b0;
            led   <= '0;
            tk    <= 1'b0;
         end else if (hit) begin
            count <= '0;
            step  <= cfg_step;
            mode  <= cfg_mode;
            dir   <= 1'b0;
            tk    <= 1'b0;
            if (cfg_clear) begin
               led <= '0;
            end
         end else if (mode == MODE_HOLD) begin
            tk <= 1'b0;
         end else if (terminal) begin
            count <= '0;
            led   <= led_nx;
            dir   <= dir_nx;
            tk    <= 1'b1;
         end else begin
            count <= count + 1'b1;
            tk    <= 1'b0;
         end
      end

      assign LED[n*WIDTH +: WIDTH] = led;
      assign tick[n]               = tk;
   end

endmodule

// File: tb/tb_multi_led_counter.sv
// tb/tb_multi_led_counter.sv - directed self-checking bench for multi_led_counter
module tb_multi_led_counter;

   localparam int CHANNELS  = 3;
   localparam int WIDTH     = 8;
   localparam int CNT_WIDTH = 32;
   localparam int STEP      = 10;

   logic                        CLK;
   logic                        RST;
   logic                        cfg_valid;
   logic                        cfg_ready;
   logic [1:0]                  cfg_ch;
   logic [CNT_WIDTH-1:0]        cfg_step;
   logic [1:0]                  cfg_mode;
   logic                        cfg_clear;
   logic [CHANNELS*WIDTH-1:0]   LED;
   logic [CHANNELS-1:0]         tick;

   int n_checks;
   int n_err;
   int cyc;

   multi_led_counter #(
      .CHANNELS (CHANNELS),
      .WIDTH    (WIDTH),
      .CNT_WIDTH(CNT_WIDTH),
      .STEP     (STEP)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready),
      .cfg_ch   (cfg_ch),
      .cfg_step (cfg_step),
      .cfg_mode (cfg_mode),
      .cfg_clear(cfg_clear),
      .LED      (LED),
      .tick     (tick)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic clk1;
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h (cyc=%0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [7:0] led_of(input int ch);
      return LED[ch*WIDTH +: WIDTH];
   endfunction

   task automatic cfg(input logic [1:0] ch, input logic [31:0] stp, input logic [1:0] md, input logic clr);
      cfg_valid = 1'b1;
      cfg_ch    = ch;
      cfg_step  = stp;
      cfg_mode  = md;
      cfg_clear = clr;
      clk1();
      cfg_valid = 1'b0;
      cfg_clear = 1'b0;
   endtask

   initial begin
      n_checks  = 0;
      n_err     = 0;
      cyc       = 0;
      RST       = 1'b1;
      cfg_valid = 1'b0;
      cfg_ch    = '0;
      cfg_step  = '0;
      cfg_mode  = '0;
      cfg_clear = 1'b0;

      // reset state
      clk1();
      clk1();
      chk("rst_led", 32'(LED), 32'h0);
      chk("rst_tick", 32'(tick), 32'h0);
      chk("rst_ready", 32'(cfg_ready), 32'h0);

      // default run: first update on the 10th edge after release
      RST = 1'b0;
      cyc = 0;
      clk1();
      chk("ready_after_rst", 32'(cfg_ready), 32'h1);
      for (int i = 1; i < 10; i++) begin
         if (i > 1) clk1();
         chk("pre_first_led0", 32'(led_of(0)), 32'h0);
         chk("pre_first_tick", 32'(tick), 32'h0);
      end
      clk1();
      chk("first_led0", 32'(led_of(0)), 32'h1);
      chk("first_tick", 32'(tick), 32'h7);
      clk1();
      chk("tick_one_cycle", 32'(tick), 32'h0);
      chk("led0_held", 32'(led_of(0)), 32'h1);
      while (cyc < 2559) clk1();
      chk("led0_ff", 32'(led_of(0)), 32'hFF);
      clk1();
      chk("led0_wrap", 32'(led_of(0)), 32'h00);
      chk("wrap_tick0", 32'(tick[0]), 32'h1);

      // ch1 down, step 3, cleared
      cfg(2'd1, 32'd3, 2'd2, 1'b1);
      chk("ch1_cfg_led", 32'(led_of(1)), 32'h0);
      chk("ch1_cfg_tick", 32'(tick), 32'h0);
      clk1();
      clk1();
      chk("ch1_hold", 32'(led_of(1)), 32'h0);
      clk1();
      chk("ch1_ff", 32'(led_of(1)), 32'hFF);
      chk("ch1_ff_tick", 32'(tick), 32'h2);
      repeat (3) clk1();
      chk("ch1_fe", 32'(led_of(1)), 32'hFE);
      repeat (3) clk1();
      chk("ch1_fd", 32'(led_of(1)), 32'hFD);
      chk("ch0_undisturbed", 32'(led_of(0)), 32'h01);
      chk("ch2_undisturbed", 32'(led_of(2)), 32'h01);
      chk("all_tick", 32'(tick), 32'h7);

      // ch2: preload up to 0xFE at step 1, then bounce
      cfg(2'd2, 32'd1, 2'd1, 1'b1);
      chk("ch2_clear", 32'(led_of(2)), 32'h0);
      chk("ch2_cfg_notick", 32'(tick[2]), 32'h0);
      repeat (254) clk1();
      chk("ch2_preload", 32'(led_of(2)), 32'hFE);
      cfg(2'd2, 32'd1, 2'd3, 1'b0);
      chk("ch2_keep", 32'(led_of(2)), 32'hFE);
      chk("ch2_keep_notick", 32'(tick[2]), 32'h0);
      for (int k = 1; k <= 258; k++) begin
         clk1();
         chk("ch2_bounce", 32'(led_of(2)), (k <= 256) ? 32'(256 - k) : 32'(k - 256));
         chk("ch2_bounce_tick", 32'(tick[2]), 32'h1);
      end
      chk("ch0_still_counting", 32'(led_of(0)), 32'((cyc / 10) % 256));

      // bring ch0 to 0x37, then pulse reset mid-period
      cfg(2'd0, 32'd1, 2'd1, 1'b1);
      chk("ch0_clear", 32'(led_of(0)), 32'h0);
      repeat (55) clk1();
      chk("ch0_37", 32'(led_of(0)), 32'h37);
      cfg(2'd0, 32'd10, 2'd1, 1'b0);
      repeat (4) clk1();
      chk("ch0_37_held", 32'(led_of(0)), 32'h37);
      RST = 1'b1;
      clk1();
      chk("midrst_led", 32'(LED), 32'h0);
      chk("midrst_tick", 32'(tick), 32'h0);
      chk("midrst_ready", 32'(cfg_ready), 32'h0);
      RST = 1'b0;
      cyc = 0;
      repeat (9) clk1();
      chk("midrst_pre", 32'(led_of(0)), 32'h0);
      clk1();
      chk("midrst_first", 32'(led_of(0)), 32'h1);
      chk("midrst_first_tick", 32'(tick), 32'h7);

      // config on ch0 exactly at its terminal count
      repeat (9) clk1();
      cfg(2'd0, 32'd4, 2'd1, 1'b0);
      chk("term_cfg_led0", 32'(led_of(0)), 32'h1);
      chk("term_cfg_tick", 32'(tick), 32'h6);
      chk("term_cfg_led1", 32'(led_of(1)), 32'h2);
      repeat (3) clk1();
      chk("term_cfg_wait", 32'(led_of(0)), 32'h1);
      clk1();
      chk("term_cfg_next", 32'(led_of(0)), 32'h2);
      chk("term_cfg_next_tick", 32'(tick[0]), 32'h1);

      // hold mode freezes ch0
      cfg(2'd0, 32'd4, 2'd0, 1'b0);
      for (int i = 0; i < 9; i++) begin
         clk1();
         chk("hold_led0", 32'(led_of(0)), 32'h2);
         chk("hold_tick0", 32'(tick[0]), 32'h0);
      end

      // step 0 updates every cycle
      cfg(2'd0, 32'd0, 2'd1, 1'b1);
      chk("step0_clear", 32'(led_of(0)), 32'h0);
      chk("step0_cfg_tick", 32'(tick[0]), 32'h0);
      for (int i = 1; i <= 3; i++) begin
         clk1();
         chk("step0_led0", 32'(led_of(0)), 32'(i));
         chk("step0_tick0", 32'(tick[0]), 32'h1);
      end

      // out-of-range channel: accepted, nothing changes
      cfg(2'd3, 32'd0, 2'd0, 1'b1);
      chk("oor_ready", 32'(cfg_ready), 32'h1);
      chk("oor_led0", 32'(led_of(0)), 32'h4);
      chk("oor_led1", 32'(led_of(1)), 32'h3);
      chk("oor_led2", 32'(led_of(2)), 32'h3);
      clk1();
      chk("oor_after_led", 32'(LED), 32'h040405);
      chk("oor_after_tick", 32'(tick), 32'h7);

      // clear + hold on ch2 leaves the others alone
      cfg(2'd2, 32'd5, 2'd0, 1'b1);
      chk("ch2_clr_led", 32'(LED), 32'h000406);
      repeat (9) clk1();
      chk("ch2_clr_later", 32'(LED), 32'h00050F);
      chk("ch2_clr_tick", 32'(tick), 32'h3);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
